// File: rtl/reg_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reg_xfer_ctrl
//  Purpose  : Command-driven sequencer that masters a shared-address register
//             bank port. It accepts one transfer command at a time and expands
//             it into bank read/write cycles:
//               LOADI : write the immediate to dst
//               MOV   : copy src to dst
//               SWAP  : exchange src and dst
//               READ  : return the value of src
//             Every command ends with a one-cycle response pulse.
//  Ports    : clk, reset                  - clock, synchronous active-high reset
//             cmd_valid/cmd_ready         - command handshake
//             cmd_op/cmd_dst/cmd_src/cmd_imm - command fields
//             rsp_valid/rsp_data          - completion pulse and result
//             busy                        - command in flight
//             bank_addr/bank_wr/bank_rd/bank_wdata/bank_rdata - bank port
//  Revision : 1.0 - initial release
// ============================================================================
module reg_xfer_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] bank_addr,
    output logic              bank_wr,
    output logic              bank_rd,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata
);

    localparam logic [1:0] C_OP_LOADI = 2'b00;
    localparam logic [1:0] C_OP_MOV   = 2'b01;
    localparam logic [1:0] C_OP_SWAP  = 2'b10;
    localparam logic [1:0] C_OP_READ  = 2'b11;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_B = 3'd2;
    localparam logic [2:0] S_WR_A = 3'd3;
    localparam logic [2:0] S_WR_B = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    logic [2:0]        r_state;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_src;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_tmp_a;
    logic [DATA_W-1:0] r_tmp_b;
    logic [DATA_W-1:0] r_rsp_data;

    // ------------------------------------------------------------------------
    // Sequencer. rsp_data is loaded on the edge entering RESP and then held
    // until the next command's RESP.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= C_OP_LOADI;
            r_dst      <= '0;
            r_src      <= '0;
            r_imm      <= '0;
            r_tmp_a    <= '0;
            r_tmp_b    <= '0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op  <= cmd_op;
                        r_dst <= cmd_dst;
                        r_src <= cmd_src;
                        r_imm <= cmd_imm;
                        r_state <= (cmd_op == C_OP_LOADI) ? S_WR_A : S_RD_A;
                    end
                end
                S_RD_A: begin
                    r_tmp_a <= bank_rdata;
                    case (r_op)
                        C_OP_SWAP: r_state <= S_RD_B;
                        C_OP_READ: begin
                            // Read data is only valid this cycle, so it goes
                            // straight to the response register.
                            r_rsp_data <= bank_rdata;
                            r_state    <= S_RESP;
                        end
                        default:   r_state <= S_WR_A;
                    endcase
                end
                S_RD_B: begin
                    r_tmp_b <= bank_rdata;
                    r_state <= S_WR_A;
                end
                S_WR_A: begin
                    if (r_op == C_OP_SWAP) begin
                        r_state <= S_WR_B;
                    end else begin
                        r_rsp_data <= (r_op == C_OP_LOADI) ? r_imm : r_tmp_a;
                        r_state    <= S_RESP;
                    end
                end
                S_WR_B: begin
                    // SWAP reports the original src value.
                    r_rsp_data <= r_tmp_a;
                    r_state    <= S_RESP;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Bank port decode. Only one of bank_rd/bank_wr is ever asserted because
    // read and write states are disjoint; IDLE and RESP drive all zeros.
    // ------------------------------------------------------------------------
    always_comb begin
        bank_addr  = '0;
        bank_wr    = 1'b0;
        bank_rd    = 1'b0;
        bank_wdata = '0;
        case (r_state)
            S_RD_A: begin
                bank_addr = r_src;
                bank_rd   = 1'b1;
            end
            S_RD_B: begin
                bank_addr = r_dst;
                bank_rd   = 1'b1;
            end
            S_WR_A: begin
                bank_addr  = r_dst;
                bank_wr    = 1'b1;
                bank_wdata = (r_op == C_OP_LOADI) ? r_imm : r_tmp_a;
            end
            S_WR_B: begin
                bank_addr  = r_src;
                bank_wr    = 1'b1;
                bank_wdata = r_tmp_b;
            end
            default: begin
                bank_addr  = '0;
            end
        endcase
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_reg_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_xfer_ctrl
//  Purpose  : Self-checking bench for reg_xfer_ctrl with an 8x16 bank model,
//             a vector table, hand-written corner sequences and randomized
//             commands checked against an array-based register model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_xfer_ctrl;

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_MOV   = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [2:0]  cmd_dst = 3'd0;
    logic [2:0]  cmd_src = 3'd0;
    logic [15:0] cmd_imm = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;
    logic [2:0]  bank_addr;
    logic        bank_wr;
    logic        bank_rd;
    logic [15:0] bank_wdata;
    logic [15:0] bank_rdata;

    reg_xfer_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .bank_addr(bank_addr), .bank_wr(bank_wr), .bank_rd(bank_rd),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
    );

    always #5 clk = ~clk;

    // Register bank environment; read data is poisoned when not enabled.
    logic        bank_clear = 1'b1;
    logic [15:0] mem [8];
    always @(posedge clk) begin
        if (bank_clear) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'h0;
        end else if (bank_wr) begin
            mem[bank_addr] <= bank_wdata;
        end
    end
    assign bank_rdata = bank_rd ? mem[bank_addr] : 16'hDEAD;

    int cyc = 0;
    int acc_cnt = 0;
    int viol = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    end
    always @(negedge clk) begin
        if ((bank_wr && bank_rd) || ((cmd_ready || rsp_valid) && (bank_wr || bank_rd)))
            viol <= viol + 1;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural register model.
    logic [15:0] mdl [8];

    task automatic mdl_cmd(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                           input logic [15:0] imm, output int lat, output logic [15:0] data);
        logic [15:0] a;
        logic [15:0] b;
        case (op)
            OP_LOADI: begin data = imm; mdl[dst] = imm; lat = 2; end
            OP_MOV:   begin data = mdl[src]; mdl[dst] = mdl[src]; lat = 3; end
            OP_SWAP:  begin
                a = mdl[src]; b = mdl[dst];
                mdl[dst] = a; mdl[src] = b;
                data = a; lat = 5;
            end
            default:  begin data = mdl[src]; lat = 2; end
        endcase
    endtask

    task automatic chk_bank(input string name);
        int bad = 0;
        for (int i = 0; i < 8; i++) if (mem[i] !== mdl[i]) bad++;
        chk(name, 32'(bad), 32'd0);
    endtask

    // Per-cycle trace of the last command (index = cycle after accept).
    logic        tr_wr [1:8];
    logic        tr_rd [1:8];
    logic [2:0]  tr_addr [1:8];
    logic [15:0] tr_wdata [1:8];
    int          acc_cyc = 0;

    // Issues one command, returns at the rsp_valid cycle (#1 after its edge).
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                          input logic [15:0] imm, input bit hold,
                          output int lat, output logic [15:0] data);
        int w = 0;
        bit busy_ok = 1'b1;
        lat = 0;
        data = 16'h0;
        while (!cmd_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (!hold) cmd_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tr_wr[c] = bank_wr; tr_rd[c] = bank_rd;
            tr_addr[c] = bank_addr; tr_wdata[c] = bank_wdata;
            if (!busy || cmd_ready) busy_ok = 1'b0;
            if (rsp_valid) begin
                lat = c; data = rsp_data;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat == 0) chk("rsp_timeout", 32'd0, 32'd1);
        chk("busy_during_cmd", 32'(busy_ok), 32'd1);
    endtask

    task automatic run_cmd(input string name, input logic [1:0] op, input logic [2:0] dst,
                           input logic [2:0] src, input logic [15:0] imm);
        int elat, alat;
        logic [15:0] edat, adat;
        mdl_cmd(op, dst, src, imm, elat, edat);
        do_cmd(op, dst, src, imm, 1'b0, alat, adat);
        chk({name, "_lat"}, 32'(alat), 32'(elat));
        chk({name, "_data"}, 32'(adat), 32'(edat));
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  dst;
        logic [2:0]  src;
        logic [15:0] imm;
        int          lat;
        logic [15:0] data;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int lat, prev_acc, acc0;
        int mlat;
        logic [15:0] dat, mdat;
        bit quiet;

        vecs[0] = '{OP_LOADI, 3'd3, 3'd0, 16'hA5A5, 2, 16'hA5A5};
        vecs[1] = '{OP_READ,  3'd0, 3'd3, 16'h0000, 2, 16'hA5A5};
        vecs[2] = '{OP_LOADI, 3'd1, 3'd0, 16'h1234, 2, 16'h1234};
        vecs[3] = '{OP_MOV,   3'd6, 3'd1, 16'h0000, 3, 16'h1234};
        vecs[4] = '{OP_READ,  3'd0, 3'd6, 16'h0000, 2, 16'h1234};
        vecs[5] = '{OP_LOADI, 3'd2, 3'd0, 16'h00FF, 2, 16'h00FF};
        vecs[6] = '{OP_LOADI, 3'd5, 3'd0, 16'hFF00, 2, 16'hFF00};
        vecs[7] = '{OP_SWAP,  3'd5, 3'd2, 16'h0000, 5, 16'h00FF};
        vecs[8] = '{OP_READ,  3'd0, 3'd2, 16'h0000, 2, 16'hFF00};
        vecs[9] = '{OP_READ,  3'd0, 3'd5, 16'h0000, 2, 16'h00FF};

        for (int i = 0; i < 8; i++) mdl[i] = 16'h0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        bank_clear = 1'b0;
        reset = 1'b0;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_bank_ctl", {27'd0, bank_wr, bank_rd, bank_addr}, 32'd0);
        chk("rst_bank_wdata", 32'(bank_wdata), 32'd0);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            mdl_cmd(vecs[i].op, vecs[i].dst, vecs[i].src, vecs[i].imm, mlat, mdat);
            do_cmd(vecs[i].op, vecs[i].dst, vecs[i].src, vecs[i].imm, 1'b0, lat, dat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_data", i), 32'(dat), 32'(vecs[i].data));
            if (i == 0)
                chk("loadi_cycle1_write", {12'd0, tr_wr[1], tr_rd[1], tr_addr[1], tr_wdata[1]},
                    {12'd0, 1'b1, 1'b0, 3'd3, 16'hA5A5});
        end
        chk_bank("bank_after_table");

        // MOV cycle trace: read src in cycle 1, write dst in cycle 2
        run_cmd("mov_trace", OP_MOV, 3'd0, 3'd1, 16'h0);
        chk("mov_cycle1_read", {1'b0, tr_wr[1], tr_rd[1], tr_addr[1]}, {1'b0, 1'b0, 1'b1, 3'd1});
        chk("mov_cycle2_write", {12'd0, tr_wr[2], tr_rd[2], tr_addr[2], tr_wdata[2]},
            {12'd0, 1'b1, 1'b0, 3'd0, 16'h1234});

        // SWAP src==dst with cmd_valid held through busy
        run_cmd("ld_r4", OP_LOADI, 3'd4, 3'd0, 16'h0F0F);
        acc0 = acc_cnt;
        mdl_cmd(OP_SWAP, 3'd4, 3'd4, 16'h0, mlat, mdat);
        do_cmd(OP_SWAP, 3'd4, 3'd4, 16'h0, 1'b1, lat, dat);
        cmd_valid = 1'b0;
        chk("swap_same_lat", 32'(lat), 32'd5);
        chk("swap_same_data", 32'(dat), 32'h0F0F);
        chk("swap_same_accepts", 32'(acc_cnt - acc0), 32'd1);
        @(posedge clk); #1;
        chk("ready_after_resp", 32'(cmd_ready), 32'd1);
        run_cmd("read_r4", OP_READ, 3'd0, 3'd4, 16'h0);

        // Reset in WR_A of SWAP src=0 dst=7
        run_cmd("ld_r0", OP_LOADI, 3'd0, 3'd0, 16'h0001);
        run_cmd("ld_r7", OP_LOADI, 3'd7, 3'd0, 16'h0002);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = OP_SWAP; cmd_src = 3'd0; cmd_dst = 3'd7;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("swap_wr_a", {12'd0, bank_wr, bank_rd, bank_addr, bank_wdata},
            {12'd0, 1'b1, 1'b0, 3'd7, 16'h0001});
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_state", {28'd0, rsp_valid, busy, bank_wr, bank_rd}, 32'd0);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (6) begin
            if (rsp_valid) quiet = 1'b0;
            @(posedge clk); #1;
        end
        chk("midrst_no_rsp", 32'(quiet), 32'd1);
        mdl[7] = 16'h0001;
        chk_bank("bank_after_midrst");
        run_cmd("read_r7", OP_READ, 3'd0, 3'd7, 16'h0);
        run_cmd("read_r0", OP_READ, 3'd0, 3'd0, 16'h0);

        // Back-to-back LOADI with cmd_valid held high
        acc0 = acc_cnt;
        prev_acc = 0;
        for (int k = 0; k < 8; k++) begin
            mdl_cmd(OP_LOADI, 3'(k), 3'd0, 16'h1000 + 16'(k), mlat, mdat);
            do_cmd(OP_LOADI, 3'(k), 3'd0, 16'h1000 + 16'(k), 1'b1, lat, dat);
            chk($sformatf("b2b%0d_data", k), 32'(dat), 32'(mdat));
            if (k > 0) chk($sformatf("b2b%0d_spacing", k), 32'(acc_cyc - prev_acc), 32'd3);
            prev_acc = acc_cyc;
        end
        cmd_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_cnt - acc0), 32'd8);
        chk_bank("bank_after_b2b");

        // Randomized commands against the model
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [2:0]  d, s;
            logic [15:0] im;
            op = 2'($urandom_range(0, 3));
            d  = 3'($urandom_range(0, 7));
            s  = 3'($urandom_range(0, 7));
            im = 16'($urandom);
            run_cmd($sformatf("rnd%0d", n), op, d, s, im);
            chk_bank($sformatf("rnd%0d_bank", n));
        end

        chk("bank_ctl_exclusive", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
